// File: rtl/uart_apb_master_pkg.sv
// Shared constants for the UART APB stream master: register map, status bit
// positions and the transfer-sequencing FSM state type.
package uart_apb_master_pkg;

  localparam logic [4:0] ADDR_TX   = 5'h00;
  localparam logic [4:0] ADDR_RX   = 5'h04;
  localparam logic [4:0] ADDR_BAUD = 5'h08;
  localparam logic [4:0] ADDR_CTRL = 5'h0C;
  localparam logic [4:0] ADDR_STAT = 5'h10;

  localparam int STAT_TXRDY    = 0;
  localparam int STAT_RXRDY    = 1;
  localparam int STAT_PARITY   = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_FRAMING  = 4;

  typedef enum logic [2:0] {
    INIT_BAUD,
    INIT_CTRL,
    POLL,
    RX_RD,
    TX_WR
  } state_e;

endpackage

// File: rtl/uart_apb_stream_master_if.sv
// APB3 register bus between the stream master and the CoreUARTapb slave.
interface uart_apb_stream_master_if;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_stream_master_xfer.sv
// APB SETUP/ACCESS sequencer: issues back-to-back transfers, latching the next
// request whenever the bus is idle or the current ACCESS completes.
module apb_xfer_engine (
  input  logic                            PCLK,
  input  logic                            PRESETN,
  uart_apb_stream_master_if.master        apb,
  input  logic [4:0]                      req_addr,
  input  logic                            req_write,
  input  logic [7:0]                      req_wdata,
  output logic                            done
);

  always_comb done = apb.PSEL && apb.PENABLE && apb.PREADY;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
    end else if (!apb.PSEL || done) begin
      apb.PSEL    <= 1'b1;
      apb.PENABLE <= 1'b0;
      apb.PADDR   <= req_addr;
      apb.PWRITE  <= req_write;
      // PWDATA only moves on a write SETUP so it holds across reads
      if (req_write)
        apb.PWDATA <= req_wdata;
    end else begin
      apb.PENABLE <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_apb_stream_master.sv
// CPU-less APB3 master for CoreUARTapb: configures baud/control once, then polls
// status and bridges TX/RX byte streams. Optional sticky errors: UART_APB_MASTER_ERR_EN.
module uart_apb_stream_master
  import uart_apb_master_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd0,
  parameter logic [2:0]  CTRL_BITS  = 3'b001
) (
  input  logic                     PCLK,
  input  logic                     PRESETN,
  uart_apb_stream_master_if.master apb,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     init_done,
  output logic [2:0]               err_status,
  input  logic                     err_clr
);

  state_e     state_q, state_d;
  logic       last_rx_q, last_rx_d;
  logic       done;
  logic       rx_elig, tx_elig;
  logic [4:0] req_addr;
  logic       req_write;
  logic [7:0] req_wdata;

  apb_xfer_engine u_xfer (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .apb       (apb),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .done      (done)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= INIT_BAUD;
      last_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rx_q <= last_rx_d;
    end
  end

  // The request presented to the engine belongs to state_d, so the next
  // SETUP is launched on the same edge that completes the current ACCESS.
  always_comb begin
    state_d   = state_q;
    last_rx_d = last_rx_q;
    tx_ready  = 1'b0;
    rx_elig   = apb.PRDATA[STAT_RXRDY] && !rx_valid;
    tx_elig   = apb.PRDATA[STAT_TXRDY] && tx_valid;
    if (done) begin
      case (state_q)
        INIT_BAUD: state_d = apb.PSLVERR ? INIT_BAUD : INIT_CTRL;
        INIT_CTRL: state_d = apb.PSLVERR ? INIT_CTRL : POLL;
        POLL: begin
          if (rx_elig && (!tx_elig || !last_rx_q)) begin
            state_d   = RX_RD;
            last_rx_d = 1'b1;
          end else if (tx_elig) begin
            state_d   = TX_WR;
            last_rx_d = 1'b0;
            tx_ready  = 1'b1;
          end else begin
            state_d = POLL;
          end
        end
        RX_RD:   state_d = POLL;
        TX_WR:   state_d = POLL;
        default: state_d = INIT_BAUD;
      endcase
    end
  end

  always_comb begin
    req_addr  = ADDR_STAT;
    req_write = 1'b0;
    req_wdata = '0;
    case (state_d)
      INIT_BAUD: begin
        req_addr  = ADDR_BAUD;
        req_write = 1'b1;
        req_wdata = BAUD_VALUE[7:0];
      end
      INIT_CTRL: begin
        req_addr  = ADDR_CTRL;
        req_write = 1'b1;
        req_wdata = {BAUD_VALUE[12:8], CTRL_BITS};
      end
      RX_RD: req_addr = ADDR_RX;
      TX_WR: begin
        req_addr  = ADDR_TX;
        req_write = 1'b1;
        req_wdata = tx_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)
      init_done <= 1'b0;
    else if (done && state_q == INIT_CTRL && !apb.PSLVERR)
      init_done <= 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (done && state_q == RX_RD && !apb.PSLVERR) begin
      rx_valid <= 1'b1;
      rx_data  <= apb.PRDATA;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef UART_APB_MASTER_ERR_EN
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)
      err_status <= '0;
    else if (done && state_q == POLL)
      err_status <= (err_clr ? 3'b000 : err_status) |
                    apb.PRDATA[STAT_FRAMING:STAT_PARITY];
    else if (err_clr)
      err_status <= '0;
  end
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign err_status     = '0;
`endif

endmodule

// File: tb/tb_uart_apb_stream_master.sv
// Directed bench for uart_apb_stream_master with a behavioural CoreUARTapb slave.
module tb_uart_apb_stream_master;

  logic PCLK = 1'b0;
  logic PRESETN;
  always #5 PCLK = ~PCLK;

  uart_apb_stream_master_if apb ();

  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, init_done, err_clr;
  logic [2:0] err_status;

  logic [7:0] stat, rxbyte;
  logic       pready, pslverr;

  assign apb.PRDATA  = (apb.PADDR == 5'h10) ? stat :
                       (apb.PADDR == 5'h04) ? rxbyte : 8'h00;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;

  uart_apb_stream_master #(
    .BAUD_VALUE (13'h1A5),
    .CTRL_BITS  (3'b011)
  ) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .apb        (apb),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .init_done  (init_done),
    .err_status (err_status),
    .err_clr    (err_clr)
  );

  typedef struct packed {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
  } xfer_t;

  xfer_t log_q[$];
  int    txp;
  int    errors = 0;
  int    checks = 0;

  always @(posedge PCLK)
    if (PRESETN && apb.PSEL && apb.PENABLE && apb.PREADY)
      log_q.push_back({apb.PWRITE, apb.PADDR, apb.PWRITE ? apb.PWDATA : apb.PRDATA});

  always @(posedge PCLK)
    if (PRESETN && tx_ready && tx_valid) txp++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic wait_setup(input logic [4:0] a, input logic w, input string nm);
    int n = 0;
    while (!(apb.PSEL && !apb.PENABLE && apb.PADDR == a && apb.PWRITE == w) && n < 60) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 60) timeout(nm);
  endtask

  task automatic wait_log(input int k, input string nm);
    int n = 0;
    while (log_q.size() < k && n < 60) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 60) timeout(nm);
  endtask

  typedef struct {
    logic [7:0] stat;
    logic [7:0] rxb;
    logic       txv;
    logic [7:0] txd;
    logic       rxr;
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    int         txp;
    logic       rxv;
    logic [7:0] rxd;
  } vec_t;

  vec_t vec[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'h10, 8'h00, 0, 1'b0, 8'h00};
    vec[1] = '{8'h01, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1, 5'h00, 8'h55, 1, 1'b0, 8'h00};
    vec[2] = '{8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'h10, 8'h01, 0, 1'b0, 8'h00};
    vec[3] = '{8'h02, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 5'h04, 8'h3C, 0, 1'b1, 8'h3C};
    vec[4] = '{8'h02, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 5'h10, 8'h02, 0, 1'b1, 8'h3C};
    vec[5] = '{8'h03, 8'h3C, 1'b1, 8'hA1, 1'b0, 1'b1, 5'h00, 8'hA1, 1, 1'b1, 8'h3C};
    vec[6] = '{8'h03, 8'h4D, 1'b1, 8'hB2, 1'b1, 1'b0, 5'h04, 8'h4D, 0, 1'b1, 8'h4D};
    vec[7] = '{8'h03, 8'h4D, 1'b1, 8'hB2, 1'b1, 1'b1, 5'h00, 8'hB2, 1, 1'b0, 8'h4D};
    vec[8] = '{8'h03, 8'h5E, 1'b1, 8'hC3, 1'b1, 1'b0, 5'h04, 8'h5E, 0, 1'b1, 8'h5E};
    vec[9] = '{8'h00, 8'h5E, 1'b0, 8'h00, 1'b1, 1'b0, 5'h10, 8'h00, 0, 1'b0, 8'h5E};

    PRESETN = 1'b0; stat = 8'h00; rxbyte = 8'h00; pready = 1'b1; pslverr = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge PCLK);

    chk("rst_psel", apb.PSEL, 0);
    chk("rst_penable", apb.PENABLE, 0);
    chk("rst_pwrite", apb.PWRITE, 0);
    chk("rst_paddr", apb.PADDR, 0);
    chk("rst_pwdata", apb.PWDATA, 0);
    chk("rst_outs", {tx_ready, rx_valid, rx_data, init_done, err_status}, 0);

    PRESETN = 1'b1;
    @(negedge PCLK);
    chk("init1_ctl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b101);
    chk("init1_addr", apb.PADDR, 5'h08);
    chk("init1_data", apb.PWDATA, 8'hA5);
    @(negedge PCLK);
    chk("init1_access", apb.PENABLE, 1);
    @(negedge PCLK);
    chk("init2_addr", apb.PADDR, 5'h0C);
    chk("init2_data", apb.PWDATA, 8'h0B);
    chk("init2_setup", apb.PENABLE, 0);
    @(negedge PCLK);
    chk("init_done_early", init_done, 0);
    @(negedge PCLK);
    chk("init_done", init_done, 1);
    chk("first_poll", {apb.PWRITE, apb.PADDR}, {1'b0, 5'h10});

    for (int i = 0; i < 10; i++) begin
      wait_setup(5'h10, 1'b0, $sformatf("v%0d_poll", i));
      log_q.delete();
      txp = 0;
      stat = vec[i].stat; rxbyte = vec[i].rxb; tx_valid = vec[i].txv;
      tx_data = vec[i].txd; rx_ready = vec[i].rxr;
      wait_log(2, $sformatf("v%0d_log", i));
      if (log_q.size() >= 2) begin
        chk($sformatf("v%0d_poll_addr", i), log_q[0].a, 5'h10);
        chk($sformatf("v%0d_xfer", i), {log_q[1].w, log_q[1].a, log_q[1].d},
            {vec[i].w, vec[i].a, vec[i].d});
      end
      chk($sformatf("v%0d_tx_ready", i), txp, vec[i].txp);
      chk($sformatf("v%0d_rx_valid", i), rx_valid, vec[i].rxv);
      chk($sformatf("v%0d_rx_data", i), rx_data, vec[i].rxd);
    end

    // TX write held by PREADY=0 for three ACCESS cycles
    wait_setup(5'h10, 1'b0, "stall_poll");
    log_q.delete(); txp = 0;
    stat = 8'h01; tx_valid = 1'b1; tx_data = 8'h77;
    wait_setup(5'h00, 1'b1, "stall_wr");
    tx_valid = 1'b0; stat = 8'h00; pready = 1'b0;
    chk("stall_setup_data", apb.PWDATA, 8'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      chk($sformatf("stall%0d_en", k), {apb.PSEL, apb.PENABLE, apb.PADDR}, {2'b11, 5'h00});
      chk($sformatf("stall%0d_data", k), apb.PWDATA, 8'h77);
    end
    pready = 1'b1;
    repeat (6) @(negedge PCLK);
    begin
      int nw = 0;
      foreach (log_q[j]) if (log_q[j].w && log_q[j].a == 5'h00) nw++;
      chk("stall_one_write", nw, 1);
    end
    chk("stall_tx_ready", txp, 1);

    // RX read answered with PSLVERR: byte discarded
    wait_setup(5'h10, 1'b0, "rderr_poll");
    stat = 8'h02; rxbyte = 8'h99; rx_ready = 1'b1;
    wait_setup(5'h04, 1'b0, "rderr_rd");
    pslverr = 1'b1; stat = 8'h00;
    @(negedge PCLK);
    wait_setup(5'h10, 1'b0, "rderr_after");
    pslverr = 1'b0;
    chk("rderr_rx_valid", rx_valid, 0);
    chk("rderr_rx_data", rx_data, 8'h5E);

    // Reset during a transfer with a byte held, then an INIT retry
    stat = 8'h02; rxbyte = 8'h66; rx_ready = 1'b0;
    wait_setup(5'h04, 1'b0, "mid_rd");
    stat = 8'h00;
    @(negedge PCLK);
    wait_setup(5'h10, 1'b0, "mid_poll");
    chk("mid_held", {rx_valid, rx_data}, {1'b1, 8'h66});
    @(negedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    chk("mid_rst_bus", {apb.PSEL, apb.PENABLE}, 2'b00);
    chk("mid_rst_rx", {rx_valid, init_done}, 2'b00);
    @(negedge PCLK);
    PRESETN = 1'b1; pslverr = 1'b1;
    @(negedge PCLK);
    chk("retry_setup1", {apb.PSEL, apb.PENABLE, apb.PADDR}, {2'b10, 5'h08});
    @(negedge PCLK);
    @(negedge PCLK);
    chk("retry_setup2", {apb.PSEL, apb.PENABLE, apb.PADDR}, {2'b10, 5'h08});
    pslverr = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("retry_ctrl", {apb.PADDR, apb.PWDATA}, {5'h0C, 8'h0B});
    wait_setup(5'h10, 1'b0, "retry_poll");
    chk("retry_init_done", init_done, 1);

    // Sticky error flags
    log_q.delete();
    stat = 8'h1C;
    wait_log(1, "err_log");
    stat = 8'h00;
`ifdef UART_APB_MASTER_ERR_EN
    chk("err_set", err_status, 3'b111);
    repeat (4) @(negedge PCLK);
    chk("err_sticky", err_status, 3'b111);
`else
    chk("err_off", err_status, 3'b000);
    repeat (4) @(negedge PCLK);
    chk("err_off_later", err_status, 3'b000);
`endif
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    chk("err_clr", err_status, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
